// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: direct-mapped BTB plus saturating direction counters, with an
// init port, MEM-stage resolution/update, mispredict/redirect and statistics.
// Latency: lookup and mispredict are combinational (0 cycles); table writes are visible
// after the next rising edge. There is no backpressure: one init write and one resolution
// can be accepted every cycle. Define GSHARE_EN to index the counters by pc XOR history.
module branch_predictor_unit #(
    parameter  int XLEN    = 32,
    parameter  int ENTRIES = 256,
    parameter  int CNT_W   = 2,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    // direct table initialisation
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_addr,
    input  logic             init_valid,
    input  logic [TAG_W-1:0] init_tag,
    input  logic [XLEN-1:0]  init_target,
    input  logic [CNT_W-1:0] init_cnt,
    // IF-stage lookup
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    // MEM-stage resolution
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    // statistics
    output logic [31:0]      br_count,
    output logic [31:0]      miss_count
);

    // Counters come out of reset weakly not-taken; the top value is the saturation limit.
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Table state
    logic             btb_valid_q  [ENTRIES];
    logic             btb_valid_d  [ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
    logic [TAG_W-1:0] btb_tag_d    [ENTRIES];
    logic [XLEN-1:0]  btb_target_q [ENTRIES];
    logic [XLEN-1:0]  btb_target_d [ENTRIES];
    logic [CNT_W-1:0] cnt_q        [ENTRIES];
    logic [CNT_W-1:0] cnt_d        [ENTRIES];

    logic [31:0]      br_count_q,   br_count_d;
    logic [31:0]      miss_count_q, miss_count_d;

    // Index/tag extraction for the lookup and update PCs
    logic [IDX_W-1:0] lk_idx, lk_cidx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx, up_cidx;
    logic [TAG_W-1:0] up_tag;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];

    // The two low PC bits are always zero for aligned instructions and never index anything.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, if_pc[1:0], upd_pc[1:0]};

`ifdef GSHARE_EN
    // Non-speculative global history: only resolved branches shift in.
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign lk_cidx = lk_idx ^ ghr_q;
    assign up_cidx = up_idx ^ ghr_q;

    // Shift the resolved direction into the history; the update itself uses the old value.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    // History register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lk_cidx = lk_idx;
    assign up_cidx = up_idx;
`endif

    // Lookup: pure read of the registered tables; pre-update contents on same-cycle writes.
    always_comb begin
        pred_hit    = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnt_q[lk_cidx][CNT_W-1];
        pred_target = pred_hit ? btb_target_q[lk_idx] : '0;
    end

    // Resolution: compare the fetch-time prediction with the actual outcome.
    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(4));
    end

    // Saturating step of the counter selected by the resolving branch.
    logic [CNT_W-1:0] up_cnt_cur, up_cnt_nxt;
    always_comb begin
        up_cnt_cur = cnt_q[up_cidx];
        up_cnt_nxt = up_cnt_cur;
        if (upd_taken) begin
            if (up_cnt_cur != CNT_MAX) begin
                up_cnt_nxt = up_cnt_cur + CNT_W'(1);
            end
        end else begin
            if (up_cnt_cur != '0) begin
                up_cnt_nxt = up_cnt_cur - CNT_W'(1);
            end
        end
    end

    // An init write to the same BTB entry takes priority over the update's table writes.
    logic upd_wr_en;
    assign upd_wr_en = upd_valid && !(init_we && (init_addr == up_idx));

    // Next table contents: update first, then init so that init wins any collision.
    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        cnt_d        = cnt_q;
        if (upd_wr_en) begin
            cnt_d[up_cidx] = up_cnt_nxt;
            if (upd_taken) begin
                btb_valid_d[up_idx]  = 1'b1;
                btb_tag_d[up_idx]    = up_tag;
                btb_target_d[up_idx] = upd_target;
            end
        end
        if (init_we) begin
            btb_valid_d[init_addr]  = init_valid;
            btb_tag_d[init_addr]    = init_tag;
            btb_target_d[init_addr] = init_target;
            cnt_d[init_addr]        = init_cnt;
        end
    end

    // Statistics: every resolution and every misprediction, wrapping at 2^32.
    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (upd_valid) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Table and statistics registers; reset clears everything and drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid_q  <= '{default: 1'b0};
            btb_tag_q    <= '{default: '0};
            btb_target_q <= '{default: '0};
            cnt_q        <= '{default: CNT_RST};
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            cnt_q        <= cnt_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb_branch_predictor_unit: scoreboard bench for branch_predictor_unit (default build).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: none on the DUT; the bench drives one operation per cycle.
module tb_branch_predictor_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 256;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 8;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_we;
    logic [IDX_W-1:0] init_addr;
    logic             init_valid;
    logic [TAG_W-1:0] init_tag;
    logic [XLEN-1:0]  init_target;
    logic [CNT_W-1:0] init_cnt;
    logic [XLEN-1:0]  if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [31:0]      br_count;
    logic [31:0]      miss_count;

    always #5 clk = ~clk;

    branch_predictor_unit #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .init_we         (init_we),
        .init_addr       (init_addr),
        .init_valid      (init_valid),
        .init_tag        (init_tag),
        .init_target     (init_target),
        .init_cnt        (init_cnt),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .br_count        (br_count),
        .miss_count      (miss_count)
    );

    typedef enum int {S_HIT, S_TAKEN, S_TGT, S_MISP, S_REDIR, S_BR, S_MISS} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_br;
    logic [31:0] exp_miss;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_HIT:   return 32'(pred_hit);
            S_TAKEN: return 32'(pred_taken);
            S_TGT:   return pred_target;
            S_MISP:  return 32'(mispredict);
            S_REDIR: return redirect_pc;
            S_BR:    return br_count;
            default: return miss_count;
        endcase
    endfunction

    task automatic push(input string tag, input sel_e s, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Let combinational outputs settle, then retire every pending expectation.
    task automatic settle();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic expect_look(input logic [31:0] pc, input logic hit, input logic tk,
                               input logic [31:0] tgt);
        if_pc = pc;
        push($sformatf("hit pc=%0h", pc), S_HIT, 32'(hit));
        push($sformatf("taken pc=%0h", pc), S_TAKEN, 32'(tk));
        push($sformatf("target pc=%0h", pc), S_TGT, tgt);
    endtask

    task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                        input logic [31:0] tgt);
        expect_look(pc, hit, tk, tgt);
        settle();
        @(negedge clk);
    endtask

    task automatic stats();
        push("br_count", S_BR, exp_br);
        push("miss_count", S_MISS, exp_miss);
        settle();
        @(negedge clk);
    endtask

    task automatic init_set(input logic [IDX_W-1:0] a, input logic v, input logic [TAG_W-1:0] t,
                            input logic [31:0] tgt, input logic [CNT_W-1:0] c);
        init_we     = 1'b1;
        init_addr   = a;
        init_valid  = v;
        init_tag    = t;
        init_target = tgt;
        init_cnt    = c;
    endtask

    task automatic init_only(input logic [IDX_W-1:0] a, input logic v, input logic [TAG_W-1:0] t,
                             input logic [31:0] tgt, input logic [CNT_W-1:0] c);
        init_set(a, v, t, tgt, c);
        settle();
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // One resolution; expected mispredict/redirect come from the reference formulas.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        logic        m;
        logic [31:0] r;
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        m = (ptk != tk) || (tk && ptk && (ptgt != tgt));
        r = tk ? tgt : pc + 32'd4;
        push($sformatf("mispredict pc=%0h", pc), S_MISP, 32'(m));
        push($sformatf("redirect pc=%0h", pc), S_REDIR, r);
        exp_br = exp_br + 32'd1;
        if (m) exp_miss = exp_miss + 32'd1;
        settle();
        @(negedge clk);
        upd_valid = 1'b0;
        init_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        init_we = 1'b0; init_addr = '0; init_valid = 1'b0; init_tag = '0;
        init_target = '0; init_cnt = '0; if_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        exp_br = '0; exp_miss = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        look(32'h100, 0, 0, 0);
        look(32'h0, 0, 0, 0);
        stats();

        // First taken branch allocates; same-cycle lookup sees pre-update contents
        expect_look(32'h100, 0, 0, 0);
        upd(32'h100, 1, 32'h200, 0, 0);
        look(32'h100, 1, 1, 32'h200);
        stats();

        // Reset counter value is weakly not-taken: taken then not-taken returns below MSB
        upd(32'h300, 1, 32'h340, 0, 0);
        upd(32'h300, 0, 0, 1, 32'h340);
        look(32'h300, 1, 0, 32'h340);

        // Decrement and saturation at zero
        upd(32'h100, 0, 0, 1, 32'h200);
        look(32'h100, 1, 0, 32'h200);
        upd(32'h100, 0, 0, 0, 0);
        upd(32'h100, 0, 0, 0, 0);
        look(32'h100, 1, 0, 32'h200);
        upd(32'h100, 0, 0, 0, 0);
        upd(32'h100, 1, 32'h200, 0, 0);
        look(32'h100, 1, 0, 32'h200);

        // Saturation at the top, then target mismatch with correct direction
        upd(32'h600, 1, 32'h640, 0, 0);
        upd(32'h600, 1, 32'h640, 1, 32'h640);
        upd(32'h600, 1, 32'h640, 1, 32'h640);
        upd(32'h600, 1, 32'h640, 1, 32'h640);
        upd(32'h600, 0, 0, 1, 32'h640);
        look(32'h600, 1, 1, 32'h640);
        upd(32'h600, 1, 32'h680, 1, 32'h640);
        look(32'h600, 1, 1, 32'h680);
        upd(32'h600, 1, 32'h680, 1, 32'h680);
        stats();

        // Aliasing: 0x500 shares index 0x40 with 0x100 and replaces its tag
        upd(32'h500, 1, 32'h540, 0, 0);
        look(32'h100, 0, 0, 0);
        look(32'h500, 1, 1, 32'h540);

        // Init and update to the same index: init wins, statistics still count
        init_set(8'h40, 1, '0, 32'h900, 2'd0);
        upd(32'h100, 1, 32'h200, 0, 0);
        look(32'h100, 1, 0, 32'h900);
        stats();

        // Init and update to different indices: both land
        init_set(8'h10, 1, '0, 32'hA00, 2'd3);
        upd(32'h300, 1, 32'h380, 0, 0);
        look(32'h40, 1, 1, 32'hA00);
        look(32'h300, 1, 1, 32'h380);

        // Init can invalidate, and writes the tag verbatim
        init_only(8'h10, 0, '0, 32'hA00, 2'd3);
        look(32'h40, 0, 0, 0);
        init_only(8'h20, 1, 22'd5, 32'hB00, 2'd2);
        look(32'h1480, 1, 1, 32'hB00);
        look(32'h80, 0, 0, 0);

        // Fall-through redirect wraps modulo 2^32
        upd(32'hFFFF_FFFC, 0, 0, 1, 0);
        stats();

        // Asynchronous reset mid-operation drops the pending update
        upd_valid = 1'b1; upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'h740;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        rst = 1'b1;
        exp_br = '0; exp_miss = '0;
        expect_look(32'h600, 0, 0, 0);
        push("br_count in reset", S_BR, exp_br);
        push("miss_count in reset", S_MISS, exp_miss);
        settle();
        @(negedge clk);
        upd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        look(32'h700, 0, 0, 0);
        look(32'h600, 0, 0, 0);
        stats();
        upd(32'h100, 1, 32'h200, 0, 0);
        look(32'h100, 1, 1, 32'h200);
        stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
